dm_resp: RTL and testbench

//  Data-memory responder: the memory end of the sisc load/store interface.

---
 rtl/dm_resp.sv | 135 +++++++++++++
 tb/tb_dm_resp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_resp.sv
// dm_resp: data-memory responder for the sisc load/store interface.
// Takes one read or write request at a time, waits WAIT_CYC cycles, then
// completes the access with a one-cycle ack. Owns the data RAM and flags
// addresses that fall outside it.
//
// Ports:
//   clk       system clock, rising edge
//   rst_f     asynchronous active-low reset
//   req       access request, held by the requester until ack
//   we        1 = write, 0 = read (qualified by req)
//   addr      16-bit word address
//   wdata     32-bit write data
//   rdata     read data, valid with ack on a read, held until the next read ack
//   ack       one-cycle completion pulse
//   addr_err  high with ack when the captured address is outside the RAM
//   busy      high whenever an access is in progress
//
// state | meaning
// IDLE  | waiting for req; req at the edge captures the access
// WAIT  | counting down wait states on the captured access
// RESP  | ack cycle; RAM access happened on the edge entering this state
module dm_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        addr_err,
  output logic        busy
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        capture;
  logic        enter_resp;

  logic [31:0] mem [DEPTH];

  // With zero wait states the RAM access happens on the capture edge itself,
  // so the live inputs stand in for the capture registers there.
  logic [15:0]           acc_addr;
  logic                  acc_we;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;

  always_comb begin
    acc_addr  = (state == IDLE) ? addr  : addr_q;
    acc_we    = (state == IDLE) ? we    : we_q;
    acc_wdata = (state == IDLE) ? wdata : wdata_q;
    acc_err   = (acc_addr >> DEPTH_LOG2) != 16'd0;
    acc_idx   = acc_addr[DEPTH_LOG2-1:0];
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_nxt = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= 16'd0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      ack      <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ack      <= enter_resp;
      addr_err <= enter_resp & acc_err;
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (enter_resp && !acc_we) begin
        rdata <= acc_err ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // RAM is not reset; the rst_f gate keeps clock edges during reset from
  // committing a write.
  always_ff @(posedge clk) begin
    if (rst_f && enter_resp && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dm_resp.sv
module tb_dm_resp;

  logic        clk;
  logic        rst_f;
  logic        req_a, we_a, req_b, we_b;
  logic [15:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(2)) u_dut_a (
    .clk(clk), .rst_f(rst_f), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .addr_err(err_a), .busy(busy_a)
  );

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .rst_f(rst_f), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ack(ack_b), .addr_err(err_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cap;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] mdl [2][1024];
  logic [31:0] last_rd [2];

  int idle_a = 0, gap_a = 0, last_ack_a = 0;
  int run_b = 0, last_run_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a flat word array plus the spec's rules on range and rdata hold.
  task automatic model_push(input bit sel, input bit w, input logic [15:0] a,
                            input logic [31:0] d, input int cap);
    exp_t e;
    e.err = (a >= 16'd1024);
    e.cap = cap;
    if (w) begin
      if (!e.err) mdl[sel][a % 1024] = d;
      e.rdata = last_rd[sel];
    end else begin
      e.rdata = e.err ? 32'd0 : mdl[sel][a % 1024];
      last_rd[sel] = e.rdata;
    end
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic check_ack(input bit sel, input logic busy_v, input logic err_v,
                           input logic [31:0] rdata_v);
    exp_t e;
    int   sz;
    sz = sel ? q_b.size() : q_a.size();
    chk(sel ? "b_busy_with_ack" : "a_busy_with_ack", 32'(busy_v), 32'd1);
    if (sz == 0) begin
      chk(sel ? "b_unexpected_ack" : "a_unexpected_ack", 32'(sz), 32'd1);
    end else begin
      e = sel ? q_b.pop_front() : q_a.pop_front();
      chk(sel ? "b_latency" : "a_latency", 32'(cyc - e.cap), sel ? 32'd0 : 32'd2);
      chk(sel ? "b_addr_err" : "a_addr_err", 32'(err_v), 32'(e.err));
      chk(sel ? "b_rdata" : "a_rdata", rdata_v, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rst_f) begin
      if (!busy_a) idle_a++;
      if (ack_a) begin
        check_ack(1'b0, busy_a, err_a, rdata_a);
        last_ack_a = cyc;
        gap_a      = idle_a;
        idle_a     = 0;
      end
      if (busy_b) run_b++;
      else if (run_b != 0) begin
        last_run_b = run_b;
        run_b      = 0;
      end
      if (ack_b) check_ack(1'b1, busy_b, err_b, rdata_b);
    end
  end

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [31:0] d);
    if (sel) begin req_b = r; we_b = w; addr_b = a; wdata_b = d; end
    else     begin req_a = r; we_a = w; addr_a = a; wdata_a = d; end
  endtask

  // One access: wait for idle, present it, record the capture edge, wait for ack.
  // churn scrambles addr/we/wdata every cycle after capture; hold keeps req high.
  task automatic issue(input bit sel, input bit w, input logic [15:0] a,
                       input logic [31:0] d, input bit churn, input bit hold);
    int n;
    int cap;
    n = 0;
    @(negedge clk);
    while ((sel ? busy_b : busy_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(sel ? busy_b : busy_a), 32'd0);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    cap = cyc;
    model_push(sel, w, a, d, cap);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (churn && !(sel ? ack_b : ack_a))
        drive(sel, 1'b1, 1'($urandom), 16'($urandom), $urandom);
    end while (!(sel ? ack_b : ack_a) && n < 50);
    if (n >= 50) chk("ack_timeout", 32'(sel ? ack_b : ack_a), 32'd1);
    if (!hold) drive(sel, 1'b0, 1'b0, 16'd0, 32'd0);
  endtask

  initial begin
    int a1, a2;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    rst_f = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_rdata", rdata_b, 32'd0);
    rst_f = 1'b1;

    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 16'(i), $urandom, 1'b0, 1'b0);

    // basic write then read
    issue(1'b0, 1'b1, 16'h0005, 32'hDEADBEEF, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 16'h0005, 32'h0, 1'b0, 1'b0);
    chk("t1_rdata", rdata_a, 32'hDEADBEEF);

    // back-to-back with req held
    issue(1'b0, 1'b1, 16'h0001, 32'h11, 1'b0, 1'b1);
    #1 a1 = last_ack_a;
    issue(1'b0, 1'b0, 16'h0001, 32'h0, 1'b0, 1'b0);
    #1 a2 = last_ack_a;
    chk("b2b_spacing", 32'(a2 - a1), 32'd4);
    chk("b2b_idle_gap", 32'(gap_a), 32'd1);
    chk("b2b_rdata", rdata_a, 32'h00000011);

    // out of range
    issue(1'b0, 1'b1, 16'h0000, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 16'h0400, 32'hFFFFFFFF, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0);
    chk("oor_addr0", rdata_a, 32'h0);
    issue(1'b0, 1'b0, 16'h0400, 32'h0, 1'b0, 1'b0);
    chk("oor_read", rdata_a, 32'h0);
    issue(1'b0, 1'b0, 16'h0005, 32'h0, 1'b0, 1'b0);

    // reset during WAIT abandons the write
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0007, 32'hA5A5A5A5);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
    rst_f = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_rdata", rdata_a, 32'd0);
    repeat (3) @(negedge clk);
    rst_f = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (4) @(negedge clk);
    issue(1'b0, 1'b0, 16'h0007, 32'h0, 1'b0, 1'b0);

    // input churn during WAIT, then sweep the low words
    issue(1'b0, 1'b1, 16'h0009, 32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b0, 16'(i), 32'h0, 1'b1, 1'b0);

    // random mix
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1024, 65535))
                                       : 16'($urandom_range(0, 15));
      issue(1'b0, 1'($urandom), ra, $urandom, 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);

    // zero-wait-state build
    issue(1'b1, 1'b1, 16'h0003, 32'hCAFEF00D, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 16'h0003, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("w0_busy_run", 32'(last_run_b), 32'd1);
    chk("w0_rdata", rdata_b, 32'hCAFEF00D);

    repeat (8) @(negedge clk);
    chk("pending_expect", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
